// File: rtl/pulse_train_controller.sv
// Programmable pulse-train scheduler: N pulses of HIGH cycles separated by LOW-cycle gaps,
// with a start/done handshake and abort. Every output is a flop or a decode of the state register.
module pulse_train_controller #(
    parameter int COUNT_WIDTH  = 8,
    parameter int LENGTH_WIDTH = 8
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    start,
    input  logic [COUNT_WIDTH-1:0]  pulse_count,
    input  logic [LENGTH_WIDTH-1:0] high_length,
    input  logic [LENGTH_WIDTH-1:0] low_length,
    input  logic                    abort,
    output logic                    start_ready,
    output logic                    busy,
    output logic                    pulse_out,
    output logic [COUNT_WIDTH-1:0]  pulses_done,
    output logic                    done,
    output logic                    aborted
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HIGH   = 2'd1,
        LOW    = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic [COUNT_WIDTH-1:0]  CNT_ONE   = COUNT_WIDTH'(1);
    localparam logic [LENGTH_WIDTH-1:0] PHASE_ONE = LENGTH_WIDTH'(1);

    state_t                  state_q, state_d;
    logic [COUNT_WIDTH-1:0]  count_cfg_q, count_cfg_d;
    logic [LENGTH_WIDTH-1:0] high_cfg_q, high_cfg_d;
    logic [LENGTH_WIDTH-1:0] low_cfg_q, low_cfg_d;
    logic [LENGTH_WIDTH-1:0] phase_q, phase_d;
    logic [COUNT_WIDTH-1:0]  pulses_done_q, pulses_done_d;
    logic                    aborted_q, aborted_d;
    logic                    pulse_q;

    // True when the pulse now finishing its high phase is the final one of the train.
    // Comparing against cfg-1 avoids the overflow a pulses_done+1 compare would hit at all-ones.
    function automatic logic is_last_pulse(input logic [COUNT_WIDTH-1:0] completed,
                                           input logic [COUNT_WIDTH-1:0] cfg);
        return completed == (cfg - CNT_ONE);
    endfunction

    always_comb begin
        state_d       = state_q;
        count_cfg_d   = count_cfg_q;
        high_cfg_d    = high_cfg_q;
        low_cfg_d     = low_cfg_q;
        phase_d       = phase_q;
        pulses_done_d = pulses_done_q;
        aborted_d     = aborted_q;

        case (state_q)
            IDLE: begin
                // Start wins over a coincident abort: abort is simply not looked at here.
                if (start) begin
                    count_cfg_d   = pulse_count;
                    high_cfg_d    = high_length;
                    low_cfg_d     = low_length;
                    pulses_done_d = '0;
                    aborted_d     = 1'b0;
                    if (pulse_count == '0 || high_length == '0) begin
                        state_d = FINISH;
                    end else begin
                        state_d = HIGH;
                        phase_d = high_length;
                    end
                end
            end

            HIGH: begin
                if (abort) begin
                    state_d   = FINISH;
                    aborted_d = 1'b1;
                end else if (phase_q == PHASE_ONE) begin
                    pulses_done_d = pulses_done_q + CNT_ONE;
                    if (is_last_pulse(pulses_done_q, count_cfg_q)) begin
                        state_d = FINISH;
                    end else if (low_cfg_q != '0) begin
                        state_d = LOW;
                        phase_d = low_cfg_q;
                    end else begin
                        phase_d = high_cfg_q;
                    end
                end else begin
                    phase_d = phase_q - PHASE_ONE;
                end
            end

            LOW: begin
                if (abort) begin
                    state_d   = FINISH;
                    aborted_d = 1'b1;
                end else if (phase_q == PHASE_ONE) begin
                    state_d = HIGH;
                    phase_d = high_cfg_q;
                end else begin
                    phase_d = phase_q - PHASE_ONE;
                end
            end

            FINISH: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q       <= IDLE;
            pulses_done_q <= '0;
            aborted_q     <= 1'b0;
            pulse_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pulses_done_q <= pulses_done_d;
            aborted_q     <= aborted_d;
            pulse_q       <= (state_d == HIGH);
        end
    end

    // Configuration and phase counter are only meaningful once a start has loaded them.
    always_ff @(posedge clock) begin
        count_cfg_q <= count_cfg_d;
        high_cfg_q  <= high_cfg_d;
        low_cfg_q   <= low_cfg_d;
        phase_q     <= phase_d;
    end

    assign start_ready = (state_q == IDLE);
    assign busy        = (state_q == HIGH) || (state_q == LOW);
    assign done        = (state_q == FINISH);
    assign pulse_out   = pulse_q;
    assign pulses_done = pulses_done_q;
    assign aborted     = aborted_q;

endmodule

// File: doc/pulse_train_controller.md
Name: pulse_train_controller

Overview:
- Sequences a programmable train of pulses: N pulses, each HIGH cycles long, separated by LOW-cycle gaps.
- Start/done handshake toward a control FSM or CSR block; drives strobe/enable lines downstream.
- Generalises the fixed-length pulse extension used across the pulse library into a runtime-configured, abortable scheduler.

Parameters:
- COUNT_WIDTH, 8, width of pulse_count and of the progress counter.
- LENGTH_WIDTH, 8, width of high_length and low_length and of the internal phase counter.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- resetn  input  1  synchronous active-low reset, sampled on rising edge of clock.
- start  input  1  request a new train; accepted when start && start_ready at a rising edge.
- pulse_count  input  COUNT_WIDTH  number of pulses; sampled only on accepted start.
- high_length  input  LENGTH_WIDTH  cycles per pulse high phase; sampled on accepted start.
- low_length  input  LENGTH_WIDTH  gap cycles between pulses; sampled on accepted start.
- abort  input  1  terminate the train in progress.
- start_ready  output  1  high only in IDLE.
- busy  output  1  high in HIGH or LOW state.
- pulse_out  output  1  the generated pulse train; registered.
- pulses_done  output  COUNT_WIDTH  completed high phases in the current or last train.
- done  output  1  one-cycle strobe at train end (normal or aborted).
- aborted  output  1  valid with done; 1 if the train ended by abort.

Behaviour:
- Reset (resetn=0 at edge): state=IDLE, pulse_out=0, busy=0, done=0, aborted=0, pulses_done=0, start_ready=1. Reset mid-train kills the train with no done strobe.
- States: IDLE, HIGH, LOW, FINISH. All outputs are registered or decoded from state registers. No combinational path from any input to any output.
- IDLE: on accepted start at edge T, latch config and clear pulses_done.
  - If pulse_count==0 or high_length==0, go to FINISH. pulse_out never rises, and done=1, aborted=0 in cycle T+1.
  - Otherwise go to HIGH with phase counter=high_length. pulse_out=1 from cycle T+1.
- HIGH: pulse_out=1. The phase counter decrements each cycle. On the last cycle of the phase (counter==1), increment pulses_done.
  - If pulses remain and low_length>0, go to LOW with counter=low_length.
  - If pulses remain and low_length==0, reload HIGH. pulse_out stays continuously high, giving count*high cycles total.
  - If no pulses remain, go to FINISH.
- LOW: pulse_out=0. Counts low_length cycles, then goes to HIGH with the counter reloaded.
- FINISH: exactly one cycle. done=1, pulse_out=0, start_ready=0, busy=0. Next state is IDLE.
- Latency from start edge to last-pulse fall: count*high + (count-1)*low cycles; done is high in the cycle pulse_out first reads 0.
- abort:
  - Sampled in HIGH or LOW: next state is FINISH, with pulse_out=0 and done=1, aborted=1 next cycle. pulses_done holds the completed-pulse count. A high phase cut short is not counted.
  - Ignored in IDLE and FINISH.
  - abort on the same edge as an accepted start: start wins and abort is ignored.
- start while not start_ready: ignored, not queued. Config inputs are don't-care outside an accepted start.
- pulses_done and aborted hold their values after FINISH until the next accepted start. done is low outside FINISH.
- Counters use decrement-to-1 compare, so no wrap. Maximum values (all-ones) are legal, e.g. 255 pulses of 255 cycles.

Test Plan:
- Reset, then start with count=3, high=2, low=1 -> pulse_out pattern 1,1,0,1,1,0,1,1 starting at T+1; done at T+9; pulses_done=3; aborted=0.
- count=2, high=3, low=0 -> pulse_out high for 6 consecutive cycles; single done after; pulses_done=2.
- count=0 (and separately high=0, count=5) -> pulse_out stays 0; done=1 at T+1; start_ready back to 1 at T+2.
- count=4, high=4, low=4; abort asserted during the 3rd pulse's 2nd high cycle -> pulse_out low next cycle; done=1, aborted=1; pulses_done=2.
- start pulsed again during busy, then start+abort together in IDLE -> the busy-time start is ignored (train unchanged); the IDLE start is accepted with abort ignored.
- resetn low mid-LOW phase -> next cycle all outputs at reset values, no done strobe; a new start is accepted immediately afterwards.
